// File: rtl/stream_check_pkg.sv
// Shared types and constants for the incrementing-stream checker.
package stream_check_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   // Width of the sync and loss run-length counters (LEN params are 1..255)
   localparam int SYNC_CNT_W = 8;
   localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/stream_seq_checker_sat_counter.sv
// Up-counter with synchronous clear; either saturates at all-ones or wraps.
module sat_counter #(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;
   logic             w_hold;

   // In saturate mode an increment at all-ones is dropped
   assign w_hold = SATURATE && (&r_count);

   // Clear takes priority over an increment in the same cycle
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         r_count <= '0;
      else if (i_inc && !w_hold)
         r_count <= r_count + WIDTH'(1);
   end

   assign o_count = r_count;

endmodule

// File: rtl/stream_seq_checker.sv
// Sink-side checker for an incrementing addr/data stream: locks on, then
// counts and captures sequence errors.
module stream_seq_checker
   import stream_check_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int SYNC_LEN      = 4,
   parameter int LOSS_LEN      = 8,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     in_valid,
   input  logic [ADDR_WIDTH-1:0]    in_addr,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic                     clear,
   output logic                     locked,
   output logic                     err_pulse,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic [31:0]              beat_count,
   output logic                     first_err_valid,
   output logic [ADDR_WIDTH-1:0]    first_err_addr,
   output logic [DATA_WIDTH-1:0]    first_err_data
);

   chk_state_t            r_state;
   logic                  r_locked;
   logic                  r_err_pulse;
   logic [SYNC_CNT_W-1:0] r_sync_cnt;
   logic [LOSS_CNT_W-1:0] r_loss_cnt;
   logic [ADDR_WIDTH-1:0] r_exp_addr;
   logic [DATA_WIDTH-1:0] r_exp_data;
   logic                  r_fe_valid;
   logic [ADDR_WIDTH-1:0] r_fe_addr;
   logic [DATA_WIDTH-1:0] r_fe_data;

   logic                  w_match;
   logic                  w_beat_ok;
   logic                  w_beat_err;
   logic [SYNC_CNT_W-1:0] w_sync_nxt;
   logic [LOSS_CNT_W-1:0] w_loss_nxt;

   assign w_match    = (in_addr == r_exp_addr) && (in_data == r_exp_data);
   assign w_beat_ok  = in_valid && (r_state == LOCKED) &&  w_match;
   assign w_beat_err = in_valid && (r_state == LOCKED) && !w_match;
   assign w_sync_nxt = r_sync_cnt + SYNC_CNT_W'(1);
   assign w_loss_nxt = r_loss_cnt + LOSS_CNT_W'(1);

   // State machine, run-length counters and expectation reload
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state     <= IDLE;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_sync_cnt  <= '0;
         r_loss_cnt  <= '0;
         r_exp_addr  <= '0;
         r_exp_data  <= '0;
      end else begin
         r_err_pulse <= w_beat_err;
         if (in_valid) begin
            // Every consumed beat reseeds, so a skip costs exactly one error
            r_exp_addr <= in_addr + ADDR_WIDTH'(1);
            r_exp_data <= in_data + DATA_WIDTH'(1);
            case (r_state)
               IDLE: begin
                  r_state    <= SYNC;
                  r_sync_cnt <= '0;
               end
               SYNC: begin
                  if (!w_match)
                     r_sync_cnt <= '0;
                  else if (w_sync_nxt == SYNC_CNT_W'(SYNC_LEN)) begin
                     r_state    <= LOCKED;
                     r_locked   <= 1'b1;
                     r_sync_cnt <= '0;
                     r_loss_cnt <= '0;
                  end else
                     r_sync_cnt <= w_sync_nxt;
               end
               LOCKED: begin
                  if (w_match)
                     r_loss_cnt <= '0;
                  else if (w_loss_nxt == LOSS_CNT_W'(LOSS_LEN)) begin
                     r_state    <= SYNC;
                     r_locked   <= 1'b0;
                     r_sync_cnt <= '0;
                     r_loss_cnt <= '0;
                  end else
                     r_loss_cnt <= w_loss_nxt;
               end
               default: begin
                  r_state  <= IDLE;
                  r_locked <= 1'b0;
               end
            endcase
         end
         // Clear is a statistics reset; loss run length counts as a statistic
         if (clear)
            r_loss_cnt <= '0;
      end
   end

   // First-error capture; clear wins over a coincident error
   always_ff @(posedge sys_clk) begin
      if (sys_rst || clear) begin
         r_fe_valid <= 1'b0;
         r_fe_addr  <= '0;
         r_fe_data  <= '0;
      end else if (w_beat_err && !r_fe_valid) begin
         r_fe_valid <= 1'b1;
         r_fe_addr  <= in_addr;
         r_fe_data  <= in_data;
      end
   end

   sat_counter #(.WIDTH(ERR_CNT_WIDTH), .SATURATE(1'b1)) u_err_cnt (
      .i_clk   (sys_clk),
      .i_rst   (sys_rst),
      .i_clr   (clear),
      .i_inc   (w_beat_err),
      .o_count (err_count)
   );

   sat_counter #(.WIDTH(32), .SATURATE(1'b0)) u_beat_cnt (
      .i_clk   (sys_clk),
      .i_rst   (sys_rst),
      .i_clr   (clear),
      .i_inc   (w_beat_ok),
      .o_count (beat_count)
   );

   assign locked          = r_locked;
   assign err_pulse       = r_err_pulse;
   assign first_err_valid = r_fe_valid;
   assign first_err_addr  = r_fe_addr;
   assign first_err_data  = r_fe_data;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed bench for stream_seq_checker with a per-cycle scoreboard.
module tb_stream_seq_checker;

   localparam int SYNC_LEN = 4;
   localparam int LOSS_LEN = 8;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_addr = '0;
   logic [31:0] in_data = '0;
   logic        clear = 1'b0;
   logic        locked, err_pulse, first_err_valid;
   logic [15:0] err_count;
   logic [31:0] beat_count, first_err_addr, first_err_data;

   int checks = 0;
   int failures = 0;
   int pulses = 0;

   stream_seq_checker #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .SYNC_LEN(SYNC_LEN),
      .LOSS_LEN(LOSS_LEN), .ERR_CNT_WIDTH(16)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid),
      .in_addr(in_addr), .in_data(in_data), .clear(clear),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
      .beat_count(beat_count), .first_err_valid(first_err_valid),
      .first_err_addr(first_err_addr), .first_err_data(first_err_data)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic        locked;
      logic        pulse;
      logic [15:0] errc;
      logic [31:0] beat;
      logic        fev;
      logic [31:0] fea;
      logic [31:0] fed;
   } exp_t;

   exp_t sb_q[$];

   // behavioural reference state
   int          m_st = 0; // 0 idle, 1 sync, 2 locked
   int          m_sync = 0, m_loss = 0;
   logic [31:0] m_ea = '0, m_ed = '0;
   exp_t        m;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic rst, input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic clr);
      logic hit;
      if (rst) begin
         m_st = 0; m_sync = 0; m_loss = 0; m_ea = '0; m_ed = '0;
         m = '{default: '0};
         return;
      end
      m.pulse = 1'b0;
      if (v) begin
         hit = (a == m_ea) && (d == m_ed);
         if (m_st == 0) begin
            m_st = 1; m_sync = 0;
         end else if (m_st == 1) begin
            if (!hit) m_sync = 0;
            else if (m_sync + 1 == SYNC_LEN) begin m_st = 2; m_sync = 0; m_loss = 0; end
            else m_sync++;
         end else begin
            if (hit) begin
               m.beat++; m_loss = 0;
            end else begin
               m.pulse = 1'b1;
               if (m.errc != 16'hFFFF) m.errc++;
               if (!m.fev) begin m.fev = 1'b1; m.fea = a; m.fed = d; end
               m_loss++;
               if (m_loss == LOSS_LEN) begin m_st = 1; m_sync = 0; m_loss = 0; end
            end
         end
         m_ea = a + 32'd1; m_ed = d + 32'd1;
      end
      if (clr) begin
         m.errc = '0; m.beat = '0; m.fev = 1'b0; m.fea = '0; m.fed = '0; m_loss = 0;
      end
      m.locked = (m_st == 2);
   endtask

   // Drive one cycle, predict, then compare one cycle later
   task automatic step(input logic rst, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic clr);
      exp_t e;
      @(negedge sys_clk);
      sys_rst = rst; in_valid = v; in_addr = a; in_data = d; clear = clr;
      model(rst, v, a, d, clr);
      sb_q.push_back(m);
      @(posedge sys_clk);
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk("sb_locked", locked, e.locked);
         chk("sb_err_pulse", err_pulse, e.pulse);
         chk("sb_err_count", err_count, e.errc);
         chk("sb_beat_count", beat_count, e.beat);
         chk("sb_fe_valid", first_err_valid, e.fev);
         chk("sb_fe_addr", first_err_addr, e.fea);
         chk("sb_fe_data", first_err_data, e.fed);
      end
      if (err_pulse) pulses++;
   endtask

   task automatic beat(input logic [31:0] x);
      step(1'b0, 1'b1, x, x, 1'b0);
   endtask

   task automatic gap();
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_pulse"}, err_pulse, 0);
      chk({tag, "_errc"}, err_count, 0);
      chk({tag, "_beat"}, beat_count, 0);
      chk({tag, "_fev"}, first_err_valid, 0);
      chk({tag, "_fea"}, first_err_addr, 0);
      chk({tag, "_fed"}, first_err_data, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x, r, last, first_bad;
      int p0;

      // clean stream
      for (int i = 0; i < 5; i++) do_reset();
      all_zero("reset");
      for (int i = 0; i < 100; i++) begin
         beat(i);
         if (i == 3) chk("clean_not_yet_locked", locked, 0);
         if (i == 4) chk("clean_locked_at_5", locked, 1);
      end
      chk("clean_errc", err_count, 0);
      chk("clean_beat", beat_count, 95);

      // skipped beat 20 -> 22
      do_reset();
      for (int i = 0; i <= 20; i++) beat(i);
      p0 = pulses;
      for (int i = 22; i <= 30; i++) begin
         beat(i);
         if (i == 22) chk("skip_pulse_now", err_pulse, 1);
      end
      chk("skip_one_pulse", pulses - p0, 1);
      chk("skip_errc", err_count, 1);
      chk("skip_fea", first_err_addr, 22);
      chk("skip_fed", first_err_data, 22);
      chk("skip_locked", locked, 1);

      // wrap during sync and during lock
      do_reset();
      x = 32'hFFFF_FFFD;
      for (int i = 0; i < 6; i++) begin beat(x); x = x + 32'd1; end
      chk("wrap_sync_locked", locked, 1);
      chk("wrap_sync_errc", err_count, 0);
      do_reset();
      x = 32'hFFFF_FFF8;
      for (int i = 0; i < 12; i++) begin beat(x); x = x + 32'd1; end
      chk("wrap_lock_locked", locked, 1);
      chk("wrap_lock_errc", err_count, 0);
      chk("wrap_lock_beat", beat_count, 7);

      // loss of lock: 8 random beats (expectation is 4)
      last = 32'd3;
      first_bad = '0;
      for (int i = 0; i < LOSS_LEN; i++) begin
         r = $urandom;
         if (r == last + 32'd1) r = r + 32'd2;
         if (i == 0) first_bad = r;
         step(1'b0, 1'b1, r, r ^ 32'h5A5A_0000, 1'b0);
         last = r;
         if (i == LOSS_LEN - 2) chk("loss_still_locked", locked, 1);
      end
      chk("loss_unlocked", locked, 0);
      chk("loss_errc", err_count, 8);
      chk("loss_fea", first_err_addr, first_bad);
      chk("loss_fed", first_err_data, first_bad ^ 32'h5A5A_0000);

      // relock, clear, build err_count=3, then clear colliding with an error
      for (int i = 1000; i <= 1004; i++) beat(i);
      chk("relock", locked, 1);
      step(1'b0, 1'b1, 32'd1005, 32'd1005, 1'b1);
      chk("clear_errc", err_count, 0);
      chk("clear_fev", first_err_valid, 0);
      beat(2000); beat(3000); beat(4000); beat(4001);
      chk("three_errc", err_count, 3);
      chk("three_fea", first_err_addr, 2000);
      chk("three_locked", locked, 1);
      step(1'b0, 1'b1, 32'd9000, 32'd9000, 1'b1);
      chk("coll_pulse", err_pulse, 1);
      chk("coll_errc", err_count, 0);
      chk("coll_fev", first_err_valid, 0);

      // 10 locked beats, reset mid-stream, then re-acquire with gaps
      for (int i = 9001; i <= 9010; i++) beat(i);
      chk("pre_rst_beat", beat_count, 10);
      do_reset();
      all_zero("midrst");
      for (int k = 0; k < 5; k++) begin
         beat(50 + k);
         if (k == 3) chk("gap_not_locked", locked, 0);
         if (k == 4) chk("gap_locked", locked, 1);
         gap();
      end
      chk("gap_errc", err_count, 0);
      chk("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
